// File: rtl/axis_stream_packer.sv
// rtl/axis_stream_packer.sv - packs a byte stream into n-byte AXI4-Stream beats
//
// Purpose: collects producer bytes into an n-lane pack register, then moves each
// completed pack into a held AXI4-Stream output beat with TID/TDEST/TSTRB/TKEEP/TLAST.
// Ports:
//   Aclk, Arst            clock, synchronous active-high reset
//   in_valid/in_ready     producer byte handshake; in_byte/in_last/in_id/in_dest payload
//   Tvalid/Tready         output beat handshake; Tdata/Tstrb/Tkeep/Tlast/Tid/Tdest payload
//   pkt_count             number of completed packets (Tlast handshakes), wraps
module axis_stream_packer #(
  parameter int n = 2,
  parameter int i = 4,
  parameter int d = 4
) (
  input  logic             Aclk,
  input  logic             Arst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  input  logic [i-1:0]     in_id,
  input  logic [d-1:0]     in_dest,
  output logic             Tvalid,
  input  logic             Tready,
  output logic [8*n-1:0]   Tdata,
  output logic [n-1:0]     Tstrb,
  output logic [n-1:0]     Tkeep,
  output logic             Tlast,
  output logic [i-1:0]     Tid,
  output logic [d-1:0]     Tdest,
  output logic [15:0]      pkt_count
);

  localparam int LW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [8*n-1:0]   pack_data_q, pack_data_d;
  logic [n-1:0]     pack_keep_q, pack_keep_d;
  logic             pack_last_q, pack_last_d;
  logic             pack_complete_q, pack_complete_d;
  logic [i-1:0]     id_q, id_d;
  logic [d-1:0]     dest_q, dest_d;

  logic             tvalid_q, tvalid_d;
  logic [8*n-1:0]   tdata_q, tdata_d;
  logic [n-1:0]     tkeep_q, tkeep_d;
  logic             tlast_q, tlast_d;
  logic [i-1:0]     tid_q, tid_d;
  logic [d-1:0]     tdest_q, tdest_d;
  logic [15:0]      pkt_count_q, pkt_count_d;

  logic accept;
  logic move;

  // A completed pack blocks further input until it has moved to the output.
  assign in_ready = !pack_complete_q && !Arst;
  assign accept   = in_valid && in_ready;
  assign move     = pack_complete_q && (!tvalid_q || Tready);

  always_comb begin
    state_d         = state_q;
    lane_d          = lane_q;
    pack_data_d     = pack_data_q;
    pack_keep_d     = pack_keep_q;
    pack_last_d     = pack_last_q;
    pack_complete_d = pack_complete_q;
    id_d            = id_q;
    dest_d          = dest_q;
    tvalid_d        = tvalid_q;
    tdata_d         = tdata_q;
    tkeep_d         = tkeep_q;
    tlast_d         = tlast_q;
    tid_d           = tid_q;
    tdest_d         = tdest_q;
    pkt_count_d     = pkt_count_q;

    // accept and move are mutually exclusive: accept needs pack_complete_q low.
    if (accept) begin
      pack_data_d[lane_q*8 +: 8] = in_byte;
      pack_keep_d[lane_q]        = 1'b1;
      if (state_q == IDLE) begin
        id_d   = in_id;
        dest_d = in_dest;
      end
      if (in_last || (lane_q == LW'(n - 1))) begin
        pack_complete_d = 1'b1;
        pack_last_d     = in_last;
        lane_d          = '0;
      end else begin
        lane_d = lane_q + 1'b1;
      end
      state_d = in_last ? IDLE : IN_PKT;
    end

    if (move) begin
      tvalid_d        = 1'b1;
      tdata_d         = pack_data_q;
      tkeep_d         = pack_keep_q;
      tlast_d         = pack_last_q;
      tid_d           = id_q;
      tdest_d         = dest_q;
      pack_complete_d = 1'b0;
      // Clear the pack so unused lanes of the next beat read as zero.
      pack_data_d     = '0;
      pack_keep_d     = '0;
      pack_last_d     = 1'b0;
    end else if (tvalid_q && Tready) begin
      tvalid_d = 1'b0;
    end

    if (tvalid_q && Tready && tlast_q) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end
  end

  always_ff @(posedge Aclk) begin
    if (Arst) begin
      state_q         <= IDLE;
      lane_q          <= '0;
      pack_data_q     <= '0;
      pack_keep_q     <= '0;
      pack_last_q     <= 1'b0;
      pack_complete_q <= 1'b0;
      id_q            <= '0;
      dest_q          <= '0;
      tvalid_q        <= 1'b0;
      tdata_q         <= '0;
      tkeep_q         <= '0;
      tlast_q         <= 1'b0;
      tid_q           <= '0;
      tdest_q         <= '0;
      pkt_count_q     <= '0;
    end else begin
      state_q         <= state_d;
      lane_q          <= lane_d;
      pack_data_q     <= pack_data_d;
      pack_keep_q     <= pack_keep_d;
      pack_last_q     <= pack_last_d;
      pack_complete_q <= pack_complete_d;
      id_q            <= id_d;
      dest_q          <= dest_d;
      tvalid_q        <= tvalid_d;
      tdata_q         <= tdata_d;
      tkeep_q         <= tkeep_d;
      tlast_q         <= tlast_d;
      tid_q           <= tid_d;
      tdest_q         <= tdest_d;
      pkt_count_q     <= pkt_count_d;
    end
  end

  assign Tvalid    = tvalid_q;
  assign Tdata     = tdata_q;
  assign Tkeep     = tkeep_q;
  assign Tstrb     = tkeep_q;
  assign Tlast     = tlast_q;
  assign Tid       = tid_q;
  assign Tdest     = tdest_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: doc/axis_stream_packer.md
AXIS_STREAM_PACKER -- requirements
Module: axis_stream_packer

Upstream feeder for the AXI4-Stream sorting slave: packs a byte-wide producer stream into n-byte AXI4-Stream beats carrying TID/TDEST/TSTRB/TKEEP/TLAST.

Interface
REQ-001 Parameter n, default 2, bytes per beat (n >= 2).
REQ-002 Parameter i, default 4, Tid width.
REQ-003 Parameter d, default 4, Tdest width.
REQ-004 Aclk  input  1  single clock; all logic on rising edge.
REQ-005 Arst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  producer byte valid.
REQ-007 in_ready  output  1  packer accepts byte this cycle.
REQ-008 in_byte  input  8  producer data byte.
REQ-009 in_last  input  1  byte is final byte of packet.
REQ-010 in_id  input  i  stream ID of packet.
REQ-011 in_dest  input  d  destination of packet.
REQ-012 Tvalid  output  1  AXIS beat valid.
REQ-013 Tready  input  1  downstream slave ready.
REQ-014 Tdata  output  8*n  beat data.
REQ-015 Tstrb  output  n  data-byte qualifier per lane.
REQ-016 Tkeep  output  n  kept-byte qualifier per lane.
REQ-017 Tlast  output  1  final beat of packet.
REQ-018 Tid  output  i  stream ID.
REQ-019 Tdest  output  d  destination.
REQ-020 pkt_count  output  16  completed packets (Tlast handshakes), wraps.

Function
REQ-021 Input handshake: byte accepted when in_valid && in_ready at rising Aclk.
REQ-022 Output handshake: beat transferred when Tvalid && Tready at rising Aclk.
REQ-023 Internal pack register + lane counter (0..n-1); byte k of a beat goes to Tdata[8k+7:8k] (first byte in lane 0).
REQ-024 Pack complete when accepted byte fills lane n-1 or has in_last=1; lane counter returns to 0.
REQ-025 in_ready = !pack_complete (registered flag); one bubble cycle per beat permitted.
REQ-026 Pack->output move when pack_complete && (!Tvalid || Tready); Tvalid set next edge, pack_complete cleared same edge.
REQ-027 Once Tvalid=1, Tvalid and Tdata/Tstrb/Tkeep/Tlast/Tid/Tdest held stable until handshake.
REQ-028 After handshake with no pending pack, Tvalid cleared next edge; back-to-back beats when pack ready.
REQ-029 Tkeep = Tstrb = 1 for filled lanes only; unused lanes Tdata byte = 8'h00, Tkeep/Tstrb bit = 0.
REQ-030 Tlast = 1 only on beat containing the in_last byte.
REQ-031 State machine: IDLE (no packet open) -> IN_PKT on first accepted byte; IN_PKT -> IDLE on accepted in_last byte; in_last on first byte: IDLE -> IDLE with single-beat packet.
REQ-032 in_id/in_dest latched on first byte of packet (IDLE acceptance); changes during IN_PKT ignored; every beat of packet carries latched values.
REQ-033 pkt_count increments by 1 per Tvalid && Tready && Tlast; 16'hFFFF wraps to 16'h0000.
REQ-034 Tvalid never depends combinationally on Tready.

Reset
REQ-035 Arst=1 at rising Aclk: Tvalid=0, Tdata=0, Tstrb=0, Tkeep=0, Tlast=0, Tid=0, Tdest=0, pkt_count=0, lane counter=0, pack_complete=0, state IDLE.
REQ-036 in_ready = 0 while Arst is 1; 1 on first cycle after deassertion.
REQ-037 Reset mid-packet or with Tvalid pending: partial pack and held beat discarded, no Tlast emitted.

Verification (n=2, i=4, d=4)
REQ-038 Bytes 11,22,33,44 (last on 44), id=1, dest=2, Tready=1 -> beats Tdata=16'h2211 Tkeep=11 Tlast=0, then 16'h4433 Tkeep=11 Tlast=1; Tid=1, Tdest=2; pkt_count=1.
REQ-039 Bytes AA,BB,CC (last on CC) -> final beat Tdata=16'h00CC, Tkeep=Tstrb=01, Tlast=1.
REQ-040 Tready=0 for 5 cycles during 6-byte packet -> Tvalid held, payload stable all 5 cycles, in_ready=0 once next beat packed; no byte lost or duplicated.
REQ-041 in_id changes 1->7 on 3rd byte of 4-byte packet -> both beats Tid=1; next packet Tid=7.
REQ-042 Arst pulse after 1st byte of packet -> Tvalid=0 next cycle, no beat emitted; following packet starts in lane 0.
REQ-043 pkt_count preset to 16'hFFFF via 65535 single-byte packets, one more -> pkt_count=16'h0000.
